// File: rtl/player_physics.sv
// player_physics: once-per-frame player movement (run/friction, jump/gravity, screen clamping, game_state gating).
// Build option: define VARIABLE_JUMP_EN to cut the jump short when btn_jump is released on the way up.
module player_physics #(
    parameter int SCREEN_W      = 640,
    parameter int PLAYER_SIZE_X = 37,
    parameter int PLAYER_SIZE_Y = 42,
    parameter int GROUND_Y      = 400,
    parameter int START_X       = 40,
    parameter int ACCEL         = 1,
    parameter int MAX_SPEED     = 6,
    parameter int JUMP_VEL      = 12,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 15,
    parameter int JUMP_CUT      = 4
) (
    input  logic        VGA_clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [3:0]  game_state,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [15:0] playerX,
    output logic [15:0] playerY,
    output logic        player_dir,
    output logic [3:0]  player_state
);

    typedef enum logic [3:0] {
        ST_STAND = 4'd0,
        ST_RUN   = 4'd1,
        ST_JUMP  = 4'd2,
        ST_FALL  = 4'd3
    } state_t;

    localparam logic [3:0]         GS_START = 4'd0;
    localparam logic [3:0]         GS_PLAY  = 4'd1;
    localparam logic signed [16:0] X_MAX    = 17'(SCREEN_W - PLAYER_SIZE_X);
    localparam logic signed [16:0] FLOOR_S  = 17'(GROUND_Y - PLAYER_SIZE_Y);
    localparam logic [15:0]        FLOOR_Y  = 16'(GROUND_Y - PLAYER_SIZE_Y);
    localparam logic [15:0]        SPAWN_X  = 16'(START_X);
    localparam logic signed [7:0]  ACC      = 8'(ACCEL);
    localparam logic signed [7:0]  VMAX     = 8'(MAX_SPEED);
    localparam logic signed [7:0]  JVEL     = 8'(JUMP_VEL);
    localparam logic signed [7:0]  GRAV     = 8'(GRAVITY);
    localparam logic signed [7:0]  VFALL    = 8'(MAX_FALL);
    localparam logic signed [7:0]  JCUT     = 8'(JUMP_CUT);
`ifdef VARIABLE_JUMP_EN
    localparam bit VAR_JUMP = 1'b1;
`else
    localparam bit VAR_JUMP = 1'b0;
`endif

    logic [2:0] btn_meta_q, btn_sync_q;
    logic       lft, rgt, jmp, jump_edge;

    logic [15:0]        x_q, x_d, y_q, y_d;
    logic               dir_q, dir_d, jprev_q, jprev_d;
    state_t             st_q, st_d;
    logic signed [7:0]  vx_q, vx_d, vy_q, vy_d;

    logic signed [7:0]  vx_h, vx_n, vy_g, vy_a, vy_n;
    logic signed [16:0] x_sum, y_sum;
    logic [15:0]        x_n, y_n;
    state_t             st_a, st_n, ground_st;
    logic               grounded;

    assign {jmp, rgt, lft} = btn_sync_q;
    assign jump_edge       = jmp & ~jprev_q;

    // Buttons come straight from the board, so bring them into the pixel clock domain first.
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            btn_meta_q <= {btn_jump, btn_right, btn_left};
            btn_sync_q <= btn_meta_q;
        end
    end

    always_comb begin
        vx_h = vx_q;
        if (lft ^ rgt) begin
            if (rgt) vx_h = (vx_q >= VMAX - ACC) ? VMAX : vx_q + ACC;
            else     vx_h = (vx_q <= ACC - VMAX) ? -VMAX : vx_q - ACC;
        end else if (vx_q > ACC) begin
            vx_h = vx_q - ACC;
        end else if (vx_q < -ACC) begin
            vx_h = vx_q + ACC;
        end else begin
            vx_h = '0;
        end

        x_sum = $signed({1'b0, x_q}) + $signed({{9{vx_h[7]}}, vx_h});
        x_n   = x_sum[15:0];
        vx_n  = vx_h;
        if (x_sum < 17'sd0) begin
            x_n  = '0;
            vx_n = '0;
        end else if (x_sum > X_MAX) begin
            x_n  = X_MAX[15:0];
            vx_n = '0;
        end
    end

    // Vertical: velocity is settled first, then applied to Y and clamped.
    always_comb begin
        vy_g = vy_q;
        if (VAR_JUMP && st_q == ST_JUMP && !jmp && vy_q < -JCUT) vy_g = -JCUT;

        vy_a     = vy_q;
        st_a     = st_q;
        grounded = 1'b0;
        case (st_q)
            ST_JUMP: begin
                vy_a = vy_g + GRAV;
                if (vy_a >= 8'sd0) st_a = ST_FALL;
            end
            ST_FALL: vy_a = (vy_q >= VFALL - GRAV) ? VFALL : vy_q + GRAV;
            default: begin
                if (jump_edge) begin
                    vy_a = -JVEL;
                    st_a = ST_JUMP;
                end else begin
                    vy_a     = '0;
                    grounded = 1'b1;
                end
            end
        endcase

        y_sum     = $signed({1'b0, y_q}) + $signed({{9{vy_a[7]}}, vy_a});
        ground_st = (vx_n == '0) ? ST_STAND : ST_RUN;
        y_n       = y_sum[15:0];
        vy_n      = vy_a;
        st_n      = st_a;
        if (grounded) begin
            y_n  = FLOOR_Y;
            vy_n = '0;
            st_n = ground_st;
        end else if (y_sum < 17'sd0) begin
            y_n  = '0;
            vy_n = '0;
            st_n = ST_FALL;
        end else if (st_q == ST_FALL && y_sum >= FLOOR_S) begin
            y_n  = FLOOR_Y;
            vy_n = '0;
            st_n = ground_st;
        end
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        st_d    = st_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        jprev_d = jprev_q;
        if (frame_tick) begin
            if (game_state == GS_START) begin
                x_d     = SPAWN_X;
                y_d     = FLOOR_Y;
                dir_d   = 1'b1;
                st_d    = ST_STAND;
                vx_d    = '0;
                vy_d    = '0;
                jprev_d = 1'b0;
            end else if (game_state == GS_PLAY) begin
                x_d     = x_n;
                y_d     = y_n;
                dir_d   = (lft ^ rgt) ? rgt : dir_q;
                st_d    = st_n;
                vx_d    = vx_n;
                vy_d    = vy_n;
                jprev_d = jmp;
            end
        end
    end

    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            x_q     <= SPAWN_X;
            y_q     <= FLOOR_Y;
            dir_q   <= 1'b1;
            st_q    <= ST_STAND;
            vx_q    <= '0;
            vy_q    <= '0;
            jprev_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            st_q    <= st_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            jprev_q <= jprev_d;
        end
    end

    assign playerX      = x_q;
    assign playerY      = y_q;
    assign player_dir   = dir_q;
    assign player_state = st_q;

endmodule
